// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, long-latency result
// return with ready handshake, issue tracking, and the arbitrated write port.
//
// Handshake: a long-latency result transfers on a rising edge where
// i_lu_valid and o_lu_ready are both high. o_lu_ready depends only on
// registered FIFO occupancy. While i_lu_valid is high and o_lu_ready is low,
// the producer holds i_lu_valid, i_lu_addr and i_lu_data stable.
interface wb_port_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
);
  localparam int CNT_F = $clog2(DEPTH) + 1;

  logic              i_wb_valid;
  logic [4:0]        i_wb_addr;
  logic [DATA_W-1:0] i_wb_data;
  logic              i_lu_valid;
  logic [4:0]        i_lu_addr;
  logic [DATA_W-1:0] i_lu_data;
  logic              o_lu_ready;
  logic              i_issue_valid;
  logic [4:0]        i_issue_rd;
  logic [31:0]       o_busy_mask;
  logic              o_rd_wren;
  logic [4:0]        o_rd_addr;
  logic [DATA_W-1:0] o_rd_data;
  logic [CNT_W-1:0]  o_contend_cnt;
  logic [CNT_F-1:0]  o_dbg_count;

  modport master (
    output i_wb_valid, i_wb_addr, i_wb_data,
    output i_lu_valid, i_lu_addr, i_lu_data,
    output i_issue_valid, i_issue_rd,
    input  o_lu_ready, o_busy_mask, o_rd_wren, o_rd_addr, o_rd_data,
    input  o_contend_cnt, o_dbg_count
  );

  modport slave (
    input  i_wb_valid, i_wb_addr, i_wb_data,
    input  i_lu_valid, i_lu_addr, i_lu_data,
    input  i_issue_valid, i_issue_rd,
    output o_lu_ready, o_busy_mask, o_rd_wren, o_rd_addr, o_rd_data,
    output o_contend_cnt, o_dbg_count
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback (always wins)
// and long-latency results (bypassed when the port is free and nothing is
// buffered, otherwise queued in order). Tracks registers with outstanding
// long-latency writes so decode can stall on hazards.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 8
) (
  input logic             i_clk,
  input logic             i_reset,
  wb_port_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_F = PTR_W + 1;
  localparam logic [CNT_F-1:0] FULL_CNT = CNT_F'(DEPTH);

  logic [4:0]        r_fifo_addr [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_F-1:0]  r_count;
  logic [31:0]       r_busy;
  logic [CNT_W-1:0]  r_contend;

  logic              w_wb_req;
  logic              w_fifo_ne;
  logic              w_lu_ready;
  logic              w_accept;
  logic              w_own_fifo;
  logic              w_own_bypass;
  logic              w_push;
  logic              w_pop;
  logic              w_contend_inc;
  logic [4:0]        w_lu_port_addr;
  logic [DATA_W-1:0] w_lu_port_data;
  logic [31:0]       w_set_mask;
  logic [31:0]       w_clr_mask;
  logic [31:0]       w_busy_next;

  assign w_wb_req     = bus.i_wb_valid && (bus.i_wb_addr != 5'd0);
  assign w_fifo_ne    = (r_count != '0);
  assign w_lu_ready   = (r_count < FULL_CNT);
  assign w_accept     = bus.i_lu_valid && w_lu_ready;
  assign w_own_fifo   = !w_wb_req && w_fifo_ne;
  // Bypass only with an empty FIFO keeps long-latency results in order.
  assign w_own_bypass = !w_wb_req && !w_fifo_ne && bus.i_lu_valid;
  assign w_push       = w_accept && !w_own_bypass;
  assign w_pop        = w_own_fifo;
  // A long-latency result is waiting only while the pipeline holds the port.
  assign w_contend_inc = w_wb_req && (w_fifo_ne || bus.i_lu_valid);

  // Select which long-latency result (queued head or bypass) could use the port.
  always_comb begin
    w_lu_port_addr = bus.i_lu_addr;
    w_lu_port_data = bus.i_lu_data;
    if (w_fifo_ne) begin
      w_lu_port_addr = r_fifo_addr[r_rd_ptr];
      w_lu_port_data = r_fifo_data[r_rd_ptr];
    end
  end

  // Drive the write port by priority; long-latency results to x0 are consumed silently.
  always_comb begin
    bus.o_rd_wren = 1'b0;
    bus.o_rd_addr = 5'd0;
    bus.o_rd_data = '0;
    if (w_wb_req) begin
      bus.o_rd_wren = 1'b1;
      bus.o_rd_addr = bus.i_wb_addr;
      bus.o_rd_data = bus.i_wb_data;
    end else if (w_own_fifo || w_own_bypass) begin
      bus.o_rd_wren = (w_lu_port_addr != 5'd0);
      bus.o_rd_addr = w_lu_port_addr;
      bus.o_rd_data = w_lu_port_data;
    end
  end

  // Scoreboard next state: clear on long-latency write, set on issue, set wins.
  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (bus.i_issue_valid && (bus.i_issue_rd != 5'd0))
      w_set_mask = 32'd1 << bus.i_issue_rd;
    if (w_own_fifo || w_own_bypass)
      w_clr_mask = 32'd1 << w_lu_port_addr;
    w_busy_next = ((r_busy & ~w_clr_mask) | w_set_mask) & ~32'd1;
  end

  // FIFO storage; contents are don't-care outside the occupied window.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.i_lu_addr;
      r_fifo_data[r_wr_ptr] <= bus.i_lu_data;
    end
  end

  // Pointers, occupancy, scoreboard and contention counter.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_busy    <= '0;
      r_contend <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_F'(1);
        2'b01:   r_count <= r_count - CNT_F'(1);
        default: r_count <= r_count;
      endcase
      r_busy <= w_busy_next;
      if (w_contend_inc && (r_contend != '1))
        r_contend <= r_contend + CNT_W'(1);
    end
  end

  assign bus.o_lu_ready    = w_lu_ready;
  assign bus.o_busy_mask   = r_busy;
  assign bus.o_contend_cnt = r_contend;
  assign bus.o_dbg_count   = r_count;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: stimulus pushes expected port writes
// into a queue, a negedge monitor pops and compares every write it sees.
module tb_wb_port_arbiter;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 8;
  localparam int W      = 5 + DATA_W;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [W-1:0] exp_q[$];

  wb_port_arbiter_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  wb_port_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic idle();
    bus.i_wb_valid    = 1'b0;
    bus.i_wb_addr     = 5'd0;
    bus.i_wb_data     = '0;
    bus.i_lu_valid    = 1'b0;
    bus.i_lu_addr     = 5'd0;
    bus.i_lu_data     = '0;
    bus.i_issue_valid = 1'b0;
    bus.i_issue_rd    = 5'd0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [DATA_W-1:0] d);
    bus.i_wb_valid = 1'b1;
    bus.i_wb_addr  = a;
    bus.i_wb_data  = d;
  endtask

  task automatic lu(input logic [4:0] a, input logic [DATA_W-1:0] d);
    bus.i_lu_valid = 1'b1;
    bus.i_lu_addr  = a;
    bus.i_lu_data  = d;
  endtask

  task automatic issue(input logic [4:0] rd);
    bus.i_issue_valid = 1'b1;
    bus.i_issue_rd    = rd;
  endtask

  task automatic expect_write(input logic [4:0] a, input logic [DATA_W-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every enabled port write must match the queue head.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (rst_n && bus.o_rd_wren) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got addr %0d data 0x%0h expected none",
                 bus.o_rd_addr, bus.o_rd_data);
      end else begin
        e = exp_q.pop_front();
        check("port_write", {27'd0, bus.o_rd_addr, bus.o_rd_data}, {27'd0, e});
      end
    end
  end

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    check("reset_busy", bus.o_busy_mask, 0);
    check("reset_contend", bus.o_contend_cnt, 0);
    check("reset_ready", bus.o_lu_ready, 1);
    check("reset_wren", bus.o_rd_wren, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Idle bypass with scoreboard clear
    issue(5'd5);
    tick();
    idle();
    lu(5'd5, 32'hDEAD_BEEF);
    expect_write(5'd5, 32'hDEAD_BEEF);
    mid();
    check("bypass_busy_before", bus.o_busy_mask, 32'h0000_0020);
    check("bypass_ready", bus.o_lu_ready, 1);
    tick();
    idle();
    mid();
    check("bypass_busy_after", bus.o_busy_mask, 0);
    tick();

    // Contention: WB x3 and LU x7 together
    wb(5'd3, 32'h11);
    lu(5'd7, 32'h22);
    expect_write(5'd3, 32'h11);
    expect_write(5'd7, 32'h22);
    mid();
    check("contend_cnt_c0", bus.o_contend_cnt, 0);
    tick();
    idle();
    mid();
    check("contend_cnt_c1", bus.o_contend_cnt, 1);
    check("contend_count_c1", bus.o_dbg_count, 1);
    tick();
    mid();
    check("contend_drained", bus.o_dbg_count, 0);
    check("contend_cnt_final", bus.o_contend_cnt, 1);
    tick();

    // Full FIFO and ordering
    expect_write(5'd1, 32'h101);
    expect_write(5'd2, 32'h102);
    expect_write(5'd3, 32'h103);
    expect_write(5'd4, 32'h104);
    expect_write(5'd8, 32'h1);
    expect_write(5'd9, 32'h2);
    expect_write(5'd10, 32'h3);
    wb(5'd1, 32'h101); lu(5'd8, 32'h1);
    mid(); check("full_ready_c0", bus.o_lu_ready, 1);
    tick();
    wb(5'd2, 32'h102); lu(5'd9, 32'h2);
    mid(); check("full_count_c1", bus.o_dbg_count, 1);
    tick();
    wb(5'd3, 32'h103); lu(5'd10, 32'h3);
    mid();
    check("full_ready_c2", bus.o_lu_ready, 0);
    check("full_count_c2", bus.o_dbg_count, 2);
    tick();
    wb(5'd4, 32'h104);
    mid(); check("full_ready_c3", bus.o_lu_ready, 0);
    tick();
    bus.i_wb_valid = 1'b0;
    mid(); check("full_ready_c4", bus.o_lu_ready, 0);
    tick();
    mid(); check("full_ready_c5", bus.o_lu_ready, 1);
    tick();
    idle();
    mid(); check("full_count_c6", bus.o_dbg_count, 1);
    tick();
    mid();
    check("full_count_c7", bus.o_dbg_count, 0);
    check("full_contend", bus.o_contend_cnt, 5);
    tick();

    // x0 handling: pipeline x0 lets FIFO head through; LU x0 consumed silently
    wb(5'd1, 32'hAA); lu(5'd4, 32'h5);
    expect_write(5'd1, 32'hAA);
    expect_write(5'd4, 32'h5);
    tick();
    idle();
    wb(5'd0, 32'h77);
    mid(); check("x0_wb_count", bus.o_dbg_count, 1);
    tick();
    idle();
    lu(5'd0, 32'h99);
    mid();
    check("x0_lu_wren", bus.o_rd_wren, 0);
    check("x0_lu_ready", bus.o_lu_ready, 1);
    tick();
    idle();
    mid();
    check("x0_lu_busy", bus.o_busy_mask, 0);
    check("x0_lu_count", bus.o_dbg_count, 0);
    check("x0_contend", bus.o_contend_cnt, 6);
    tick();

    // Scoreboard race: issue and bypass clear of x12 in one cycle
    issue(5'd12);
    tick();
    idle();
    issue(5'd12);
    lu(5'd12, 32'hC0C0);
    expect_write(5'd12, 32'hC0C0);
    tick();
    idle();
    mid(); check("race_busy", bus.o_busy_mask, 32'h0000_1000);
    tick();

    // Reset mid-operation with two buffered results
    wb(5'd1, 32'h31); lu(5'd20, 32'h40); issue(5'd8);
    expect_write(5'd1, 32'h31);
    tick();
    idle();
    wb(5'd2, 32'h32); lu(5'd21, 32'h41);
    expect_write(5'd2, 32'h32);
    tick();
    idle();
    wb(5'd3, 32'h33);
    expect_write(5'd3, 32'h33);
    mid();
    check("prereset_busy", bus.o_busy_mask, 32'h0000_1100);
    check("prereset_count", bus.o_dbg_count, 2);
    check("prereset_ready", bus.o_lu_ready, 0);
    #2;
    idle();
    rst_n = 1'b0;
    #1;
    check("midreset_count", bus.o_dbg_count, 0);
    check("midreset_ready", bus.o_lu_ready, 1);
    check("midreset_busy", bus.o_busy_mask, 0);
    check("midreset_wren", bus.o_rd_wren, 0);
    check("midreset_contend", bus.o_contend_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      mid();
    end
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency unit (iterative divider / MMIO load return). Pipeline writeback always wins; long-latency results are bypassed when the port is free or buffered in a small FIFO. A 32-bit scoreboard of registers with outstanding long-latency writes is kept so decode can stall on RAW/WAW hazards. The block sits between WB/LSU and the register file, which samples the write port on the falling clock edge.

## Interface
- DATA_W, 32, register data width
- DEPTH, 2, long-latency result FIFO entries (power of two, ≥2)
- CNT_W, 8, width of saturating contention counter

- i_clk  in  1  clock; state updates on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_wb_valid  in  1  pipeline writeback valid
- i_wb_addr  in  5  pipeline destination register
- i_wb_data  in  DATA_W  pipeline writeback data
- i_lu_valid  in  1  long-latency result valid
- i_lu_addr  in  5  long-latency destination register
- i_lu_data  in  DATA_W  long-latency result data
- o_lu_ready  out  1  result accepted this cycle when high with i_lu_valid
- i_issue_valid  in  1  long-latency op issued this cycle
- i_issue_rd  in  5  destination of issued op
- o_busy_mask  out  32  bit n = x_n has outstanding long-latency write
- o_rd_wren  out  1  register-file write enable
- o_rd_addr  out  5  register-file write address
- o_rd_data  out  DATA_W  register-file write data
- o_contend_cnt  out  CNT_W  cycles a long-latency result waited for the port (saturating)

## Operation
- Port owner each cycle, priority order:
  1. Pipeline: i_wb_valid && i_wb_addr != 0.
  2. FIFO head: FIFO non-empty.
  3. Bypass: i_lu_valid, FIFO empty. Result goes straight to port, not pushed.
  4. None: o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
- o_rd_* are combinational from current inputs and registered FIFO state.
- o_lu_ready = (count < DEPTH). It depends only on registered state, with no combinational path from i_lu_valid.
- Accept (i_lu_valid && o_lu_ready):
  - Bypass when it owns the port.
  - Otherwise push to FIFO tail.
- FIFO ordering:
  - FIFO head pops when it owns the port.
  - Push and pop may occur in the same cycle; count is then unchanged.
  - Order of long-latency results is preserved; bypass is only allowed with the FIFO empty.
- x0 handling:
  - Pipeline write to x0: treated as no pipeline request, so a lower-priority source may use the port.
  - Long-latency result to x0: accepted and consumed normally, but o_rd_wren stays 0 for it.
- Scoreboard:
  - Set bit i_issue_rd on i_issue_valid (rd≠0).
  - Clear bit o_rd_addr when a long-latency result (FIFO or bypass) drives the port.
  - Set and clear on the same register in the same cycle: set wins.
  - Bit 0 is constant 0.
- o_contend_cnt increments each cycle where the FIFO is non-empty or a bypass-eligible i_lu_valid loses the port to the pipeline. It saturates at all-ones and clears only on reset.
- Decode must not issue to, or writeback, a busy register. Such a violation is outside contract; behaviour is priority order above, with no error flag.

## Timing
- Reset (i_reset=0, asynchronous):
  - FIFO empty, count=0, o_busy_mask=0, o_contend_cnt=0.
  - Hence o_lu_ready=1 and o_rd_wren=0 while reset is held.
  - Reset mid-operation discards buffered results and pending scoreboard bits.
- Bypass latency: result on the port in the same cycle as acceptance; the register file captures it at that cycle's falling edge.
- Buffered latency: ≥1 cycle; written in the first cycle with no pipeline request.
- Scoreboard updates at the rising edge ending the cycle of issue or write. A reader sees bit clear the cycle after the port write, by which time the register file already holds the data.
- FIFO full: o_lu_ready=0. The long-latency unit must hold valid/addr/data stable until accepted.
- Continuous pipeline writeback starves the FIFO indefinitely. This is accepted behaviour: the pipeline cannot stall at WB.
- Pointers wrap modulo DEPTH. count has width log2(DEPTH)+1.

## Test plan
- **Idle bypass:** issue rd=5; later i_lu_valid, addr=5, data=0xDEAD_BEEF, with no WB → same cycle o_rd_wren=1, o_rd_addr=5, o_rd_data=0xDEADBEEF; o_busy_mask[5] 1→0 the next edge.
- **Contention:**
  - Stimulus: WB x3=0x11 and LU x7=0x22 in the same cycle, then idle.
  - Response: cycle 0 writes x3; cycle 1 writes x7 from FIFO; o_contend_cnt=1.
- **Full/ordering:**
  - Stimulus: WB valid for 4 cycles while LU presents x8=1, x9=2, x10=3.
  - Response: first two accepted; o_lu_ready=0 with count=2; x10 held.
  - After WB stops, writes appear in order x8, x9, x10 in consecutive cycles.
- **x0 handling:**
  - WB to x0 with FIFO holding x4=0x5 → x4 written that cycle.
  - LU result to x0 → accepted, o_rd_wren=0, no scoreboard change.
- **Scoreboard race:** issue rd=12 in the same cycle a pending x12 result is bypassed → o_busy_mask[12] remains 1.
- **Reset mid-operation:**
  - Stimulus: FIFO holding 2 entries, busy mask 0x0000_1100; assert i_reset between clock edges.
  - Response: immediately count=0, o_lu_ready=1, o_busy_mask=0, o_rd_wren=0; no buffered writes after release.
